// File: rtl/alu_ctrl_exec.sv
// rtl/alu_ctrl_exec.sv - execute-stage ALU with funct/ALUOp decode and iterative multiplier
module alu_ctrl_exec #(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 1
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [9:0]      funct_i,
   input  logic [1:0]      ALUOp_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic            flush_i,
   output logic            valid_o,
   output logic [XLEN-1:0] result_o,
   output logic            zero_o,
   output logic [3:0]      ALUCtrl_o,
   output logic            illegal_o,
   output logic            busy_o
);

   localparam int N_STEPS = XLEN / MUL_STEP;
   localparam int CNT_W   = $clog2(N_STEPS + 1);
   localparam int SH_W    = $clog2(XLEN);

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(N_STEPS - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_MUL  = 1'b1;

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_XOR  = 4'd1;
   localparam logic [3:0] OP_SLL  = 4'd2;
   localparam logic [3:0] OP_ADD  = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_MUL  = 4'd5;
   localparam logic [3:0] OP_ADDI = 4'd6;
   localparam logic [3:0] OP_SRAI = 4'd7;
   localparam logic [3:0] OP_LSW  = 4'd8;
   localparam logic [3:0] OP_BEQ  = 4'd9;
   localparam logic [3:0] OP_ILL  = 4'hF;

   logic [0:0]      state;
   logic [CNT_W-1:0] counter;
   logic [XLEN-1:0] acc;
   logic [XLEN-1:0] mul_a;
   logic [XLEN-1:0] mul_b;

   logic [3:0]      dec_code;
   logic [XLEN-1:0] alu_res;
   logic [SH_W-1:0] shamt;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] b_bits;
   logic [XLEN-1:0] acc_next;

   assign ready_o = (state == ST_IDLE);
   assign busy_o  = ~ready_o;
   assign shamt   = b_i[SH_W-1:0];

   // Decode ALUOp/funct into a control code; anything unmatched falls to illegal
   always_comb begin
      dec_code = OP_ILL;
      case (ALUOp_i)
         2'b10: begin
            case (funct_i)
               10'b0000000_111: dec_code = OP_AND;
               10'b0000000_100: dec_code = OP_XOR;
               10'b0000000_001: dec_code = OP_SLL;
               10'b0000000_000: dec_code = OP_ADD;
               10'b0100000_000: dec_code = OP_SUB;
               10'b0000001_000: dec_code = OP_MUL;
               default:         dec_code = OP_ILL;
            endcase
         end
         2'b00: begin
            // funct7 carries immediate bits here, so only funct3 is decoded
            case (funct_i[2:0])
               3'b000:  dec_code = OP_ADDI;
               3'b101:  dec_code = OP_SRAI;
               3'b010:  dec_code = OP_LSW;
               default: dec_code = OP_ILL;
            endcase
         end
         2'b01:   dec_code = OP_BEQ;
         default: dec_code = OP_ILL;
      endcase
   end

   // Single-cycle datapath; illegal and MUL codes yield zero here
   always_comb begin
      alu_res = '0;
      case (dec_code)
         OP_AND:                  alu_res = a_i & b_i;
         OP_XOR:                  alu_res = a_i ^ b_i;
         OP_SLL:                  alu_res = a_i << shamt;
         OP_ADD, OP_ADDI, OP_LSW: alu_res = a_i + b_i;
         OP_SUB, OP_BEQ:          alu_res = a_i - b_i;
         OP_SRAI:                 alu_res = $signed(a_i) >>> shamt;
         default:                 alu_res = '0;
      endcase
   end

   // One multiplier step; the issue cycle itself retires the first MUL_STEP bits
   always_comb begin
      src_a  = (state == ST_IDLE) ? a_i : mul_a;
      src_b  = (state == ST_IDLE) ? b_i : mul_b;
      b_bits = '0;
      b_bits[MUL_STEP-1:0] = src_b[MUL_STEP-1:0];
      acc_next = ((state == ST_IDLE) ? '0 : acc) + (src_a * b_bits);
   end

   // Issue, multiplier sequencing, flush and result registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= ST_IDLE;
         counter   <= '0;
         acc       <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         valid_o   <= 1'b0;
         result_o  <= '0;
         zero_o    <= 1'b1;
         ALUCtrl_o <= 4'd0;
         illegal_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         if (flush_i) begin
            state   <= ST_IDLE;
            counter <= '0;
         end else if (state == ST_IDLE) begin
            if (valid_i) begin
               ALUCtrl_o <= dec_code;
               if (dec_code == OP_MUL) begin
                  if (N_STEPS == 1) begin
                     result_o  <= acc_next;
                     zero_o    <= (acc_next == '0);
                     illegal_o <= 1'b0;
                     valid_o   <= 1'b1;
                  end else begin
                     // counter holds the steps still owed after the issue-cycle step
                     acc     <= acc_next;
                     mul_a   <= a_i << MUL_STEP;
                     mul_b   <= b_i >> MUL_STEP;
                     counter <= CNT_START;
                     state   <= ST_MUL;
                  end
               end else begin
                  result_o  <= alu_res;
                  zero_o    <= (alu_res == '0);
                  illegal_o <= (dec_code == OP_ILL);
                  valid_o   <= 1'b1;
               end
            end
         end else begin
            acc     <= acc_next;
            mul_a   <= mul_a << MUL_STEP;
            mul_b   <= mul_b >> MUL_STEP;
            counter <= counter - CNT_ONE;
            if (counter == CNT_ONE) begin
               result_o  <= acc_next;
               zero_o    <= (acc_next == '0);
               illegal_o <= 1'b0;
               valid_o   <= 1'b1;
               state     <= ST_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// tb/tb_alu_ctrl_exec.sv - self-checking bench for alu_ctrl_exec (MUL_STEP 1 and 4)
module tb_alu_ctrl_exec;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_i;
   logic [9:0]  funct;
   logic [1:0]  aluop;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;

   logic        rdy1, vo1, z1, ill1, busy1;
   logic [31:0] r1;
   logic [3:0]  c1;
   logic        rdy4, vo4, z4, ill4, busy4;
   logic [31:0] r4;
   logic [3:0]  c4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_ctrl_exec #(.XLEN(32), .MUL_STEP(1)) u1 (
      .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .ready_o(rdy1),
      .funct_i(funct), .ALUOp_i(aluop), .a_i(a), .b_i(b), .flush_i(flush),
      .valid_o(vo1), .result_o(r1), .zero_o(z1), .ALUCtrl_o(c1),
      .illegal_o(ill1), .busy_o(busy1)
   );

   alu_ctrl_exec #(.XLEN(32), .MUL_STEP(4)) u4 (
      .clk_i(clk), .rst_i(rst_n), .valid_i(valid_i), .ready_o(rdy4),
      .funct_i(funct), .ALUOp_i(aluop), .a_i(a), .b_i(b), .flush_i(flush),
      .valid_o(vo4), .result_o(r4), .zero_o(z4), .ALUCtrl_o(c4),
      .illegal_o(ill4), .busy_o(busy4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] op, input logic [9:0] f,
                        input logic [31:0] av, input logic [31:0] bv);
      aluop = op; funct = f; a = av; b = bv; valid_i = 1'b1;
      step();
      valid_i = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rdy1"}, 32'(rdy1), 32'd1);
      chk({tag, "_vo1"}, 32'(vo1), 32'd0);
      chk({tag, "_res1"}, r1, 32'd0);
      chk({tag, "_zero1"}, 32'(z1), 32'd1);
      chk({tag, "_ctrl1"}, 32'(c1), 32'd0);
      chk({tag, "_ill1"}, 32'(ill1), 32'd0);
      chk({tag, "_busy1"}, 32'(busy1), 32'd0);
      chk({tag, "_rdy4"}, 32'(rdy4), 32'd1);
      chk({tag, "_res4"}, r4, 32'd0);
      chk({tag, "_zero4"}, 32'(z4), 32'd1);
      chk({tag, "_busy4"}, 32'(busy4), 32'd0);
   endtask

   // Reference: the instruction table and plain 32-bit arithmetic
   function automatic void model(input logic [1:0] op, input logic [9:0] f,
                                 input logic [31:0] av, input logic [31:0] bv,
                                 output logic [3:0] code, output logic [31:0] res);
      code = 4'hF;
      res  = 32'd0;
      if (op == 2'b10) begin
         if      (f == {7'b0000000, 3'b111}) begin code = 4'd0; res = av & bv; end
         else if (f == {7'b0000000, 3'b100}) begin code = 4'd1; res = av ^ bv; end
         else if (f == {7'b0000000, 3'b001}) begin code = 4'd2; res = av << bv[4:0]; end
         else if (f == {7'b0000000, 3'b000}) begin code = 4'd3; res = av + bv; end
         else if (f == {7'b0100000, 3'b000}) begin code = 4'd4; res = av - bv; end
         else if (f == {7'b0000001, 3'b000}) begin code = 4'd5; res = av * bv; end
      end else if (op == 2'b00) begin
         if      (f[2:0] == 3'b000) begin code = 4'd6; res = av + bv; end
         else if (f[2:0] == 3'b101) begin code = 4'd7; res = 32'($signed(av) >>> bv[4:0]); end
         else if (f[2:0] == 3'b010) begin code = 4'd8; res = av + bv; end
      end else if (op == 2'b01) begin
         code = 4'd9; res = av - bv;
      end
   endfunction

   // Issue one op and wait (bounded) for each instance's valid_o
   task automatic run_op(input string tag, input logic [1:0] op, input logic [9:0] f,
                         input logic [31:0] av, input logic [31:0] bv);
      logic [3:0]  ecode;
      logic [31:0] eres;
      int lat1, lat4;
      logic [31:0] g1, g4;
      logic gz1, gz4, gi1, gi4;
      logic [3:0] gc1, gc4;
      model(op, f, av, bv, ecode, eres);
      issue(op, f, av, bv);
      lat1 = 0; lat4 = 0;
      g1 = '0; g4 = '0; gz1 = 0; gz4 = 0; gi1 = 0; gi4 = 0; gc1 = '0; gc4 = '0;
      for (int k = 1; k <= 40 && (lat1 == 0 || lat4 == 0); k++) begin
         if (vo1 && lat1 == 0) begin lat1 = k; g1 = r1; gz1 = z1; gi1 = ill1; gc1 = c1; end
         if (vo4 && lat4 == 0) begin lat4 = k; g4 = r4; gz4 = z4; gi4 = ill4; gc4 = c4; end
         if (lat1 == 0 || lat4 == 0) step();
      end
      chk({tag, "_lat1"}, 32'(lat1), (ecode == 4'd5) ? 32'd32 : 32'd1);
      chk({tag, "_lat4"}, 32'(lat4), (ecode == 4'd5) ? 32'd8 : 32'd1);
      chk({tag, "_res1"}, g1, eres);
      chk({tag, "_res4"}, g4, eres);
      chk({tag, "_zero1"}, 32'(gz1), 32'(eres == 32'd0));
      chk({tag, "_ill1"}, 32'(gi1), 32'(ecode == 4'hF));
      chk({tag, "_ill4"}, 32'(gi4), 32'(ecode == 4'hF));
      chk({tag, "_ctrl1"}, 32'(gc1), 32'(ecode));
      chk({tag, "_ctrl4"}, 32'(gc4), 32'(ecode));
      chk({tag, "_zero4"}, 32'(gz4), 32'(eres == 32'd0));
   endtask

   initial begin : main
      logic [9:0] flist [6] = '{10'h007, 10'h004, 10'h001, 10'h000, 10'h100, 10'h008};
      int low1, low4, at1, at4, n1, n4, busy_bad;
      logic [31:0] m1, m4;
      logic [1:0]  rop;
      logic [9:0]  rf;

      rst_n = 1'b0; valid_i = 1'b0; flush = 1'b0;
      funct = '0; aluop = '0; a = '0; b = '0;
      step(); step();
      rst_n = 1'b1;
      step();
      chk_reset("reset");

      // ADD 5 + 7
      issue(2'b10, 10'h000, 32'd5, 32'd7);
      chk("add_valid", 32'(vo1), 32'd1);
      chk("add_res1", r1, 32'd12);
      chk("add_zero", 32'(z1), 32'd0);
      chk("add_ctrl", 32'(c1), 32'd3);
      chk("add_res4", r4, 32'd12);

      // BEQ then SRAI back-to-back
      aluop = 2'b01; funct = 10'h000; a = 32'h1234; b = 32'h1234; valid_i = 1'b1;
      step();
      chk("beq_valid", 32'(vo1), 32'd1);
      chk("beq_res", r1, 32'd0);
      chk("beq_zero", 32'(z1), 32'd1);
      chk("beq_ctrl", 32'(c1), 32'd9);
      aluop = 2'b00; funct = {7'b0100000, 3'b101}; a = 32'h8000_0000; b = 32'd4;
      step();
      valid_i = 1'b0;
      chk("srai_valid", 32'(vo1), 32'd1);
      chk("srai_res", r1, 32'hF800_0000);
      chk("srai_ctrl", 32'(c1), 32'd7);
      step();
      chk("pulse_end", 32'(vo1), 32'd0);

      // MUL 3 * 0xFFFFFFFE timing on both step widths
      issue(2'b10, 10'h008, 32'd3, 32'hFFFF_FFFE);
      low1 = 0; low4 = 0; at1 = 0; at4 = 0; n1 = 0; n4 = 0; busy_bad = 0; m1 = '0; m4 = '0;
      for (int k = 1; k <= 40; k++) begin
         if (!rdy1) low1++;
         if (!rdy4) low4++;
         if (busy1 !== ~rdy1 || busy4 !== ~rdy4) busy_bad++;
         if (vo1) begin n1++; if (at1 == 0) begin at1 = k; m1 = r1; end end
         if (vo4) begin n4++; if (at4 == 0) begin at4 = k; m4 = r4; end end
         step();
      end
      chk("mul_low1", 32'(low1), 32'd31);
      chk("mul_at1", 32'(at1), 32'd32);
      chk("mul_res1", m1, 32'hFFFF_FFFA);
      chk("mul_pulses1", 32'(n1), 32'd1);
      chk("mul_low4", 32'(low4), 32'd7);
      chk("mul_at4", 32'(at4), 32'd8);
      chk("mul_res4", m4, 32'hFFFF_FFFA);
      chk("mul_pulses4", 32'(n4), 32'd1);
      chk("mul_busy", 32'(busy_bad), 32'd0);
      chk("mul_ctrl", 32'(c1), 32'd5);

      // Illegal decodes
      issue(2'b10, 10'h3FF, 32'd9, 32'd9);
      chk("ill_r_valid", 32'(vo1), 32'd1);
      chk("ill_r_flag", 32'(ill1), 32'd1);
      chk("ill_r_ctrl", 32'(c1), 32'hF);
      chk("ill_r_res", r1, 32'd0);
      chk("ill_r_zero", 32'(z1), 32'd1);
      issue(2'b11, 10'h000, 32'd9, 32'd2);
      chk("ill_op_valid", 32'(vo4), 32'd1);
      chk("ill_op_flag", 32'(ill4), 32'd1);
      chk("ill_op_ctrl", 32'(c4), 32'hF);
      chk("ill_op_res", r4, 32'd0);

      // Flush a MUL in flight at cycle 10
      issue(2'b10, 10'h000, 32'd20, 32'd22);
      chk("pre_flush_res", r1, 32'd42);
      issue(2'b10, 10'h008, 32'd3, 32'd5);
      n1 = 0;
      for (int k = 1; k < 10; k++) begin
         if (vo1) n1++;
         step();
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_rdy", 32'(rdy1), 32'd1);
      chk("flush_valid", 32'(vo1), 32'd0);
      chk("flush_res_hold", r1, 32'd42);
      chk("flush_ctrl_hold", 32'(c1), 32'd5);
      for (int k = 0; k < 30; k++) begin
         if (vo1) n1++;
         step();
      end
      chk("flush_no_valid", 32'(n1), 32'd0);
      issue(2'b10, 10'h000, 32'd1, 32'd1);
      chk("post_flush_res1", r1, 32'd2);
      chk("post_flush_res4", r4, 32'd2);

      // Reset in the middle of a MUL
      issue(2'b10, 10'h008, 32'd3, 32'd7);
      for (int k = 1; k < 5; k++) step();
      #2 rst_n = 1'b0;
      #1;
      chk_reset("rst_mid");
      step(); step();
      rst_n = 1'b1;
      n1 = 0; n4 = 0;
      for (int k = 0; k < 40; k++) begin
         if (vo1) n1++;
         if (vo4) n4++;
         step();
      end
      chk("rst_no_valid1", 32'(n1), 32'd0);
      chk("rst_no_valid4", 32'(n4), 32'd0);
      chk_reset("rst_after");

      // Randomised ops against the reference
      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         rf  = flist[$urandom_range(0, 5)];
         if ($urandom_range(0, 3) == 0) rf = 10'($urandom);
         run_op($sformatf("rnd%0d", i), rop, rf, $urandom, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
